// File: rtl/control_sequencer.sv
// control_sequencer -- hardwired fetch/execute control unit for a simple
// bus-based datapath.
//
// Each instruction runs through fetch (T0-T2) and then decode/execute
// (T3-T5). The datapath strobes are Moore outputs, decoded from the state
// register and the IR fields.
//
// Ports:
//   clk        in   sole clock; all state changes on the rising edge
//   clr        in   synchronous active-high reset to IDLE (beats run/mem_ready)
//   run        in   level request to keep fetching/executing
//   mem_ready  in   memory read data valid (only used with SEQ_MEM_WAIT_EN)
//   ir[31:0]   in   opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15]
//   bus_sel    out  one-hot bus driver: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHigh,
//                   19 ZLow, 20 PC, 21 MDR, 22 InPort, 23 C
//   reg_in     out  one-hot R0-R15 load enables (R0 is never loaded)
//   pc_in, ir_in, mar_in, mdr_in, y_in, z_in, read, inc_pc
//              out  datapath strobes
//   alu_op     out  ALU function select
//   instr_done, illegal, halted
//              out  status
//
// Build option: define SEQ_MEM_WAIT_EN to hold T1 until mem_ready=1.
// Without it, T1 lasts one cycle and mem_ready is ignored.

module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [23:0] bus_sel,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        read,
  output logic        inc_pc,
  output logic [3:0]  alu_op,
  output logic        instr_done,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE, T0, T1, T2, T3, T4, T5, HALT
  } state_t;

  localparam logic [4:0] OP_ALU_MAX = 5'd11;
  localparam logic [4:0] OP_NOP     = 5'b11010;
  localparam logic [4:0] OP_HALT    = 5'b11011;

  localparam int unsigned BUS_ZLOW = 19;
  localparam int unsigned BUS_PC   = 20;
  localparam int unsigned BUS_MDR  = 21;

  state_t     state_q, state_d;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       mem_go;

  assign opcode = ir[31:27];
  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];

`ifdef SEQ_MEM_WAIT_EN
  logic unused_ir_low;
  assign unused_ir_low = ^ir[14:0];
  assign mem_go        = mem_ready;
`else
  logic unused_ir_low;
  assign unused_ir_low = ^{ir[14:0], mem_ready};
  assign mem_go        = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    bus_sel    = '0;
    reg_in     = '0;
    pc_in      = 1'b0;
    ir_in      = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    read       = 1'b0;
    inc_pc     = 1'b0;
    alu_op     = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = T0;
      end
      T0: begin
        bus_sel[BUS_PC] = 1'b1;
        mar_in          = 1'b1;
        inc_pc          = 1'b1;
        z_in            = 1'b1;
        state_d         = T1;
      end
      T1: begin
        bus_sel[BUS_ZLOW] = 1'b1;
        pc_in             = 1'b1;
        read              = 1'b1;
        mdr_in            = 1'b1;
        if (mem_go) state_d = T2;
      end
      T2: begin
        bus_sel[BUS_MDR] = 1'b1;
        ir_in            = 1'b1;
        state_d          = T3;
      end
      T3: begin
        if (opcode <= OP_ALU_MAX) begin
          bus_sel[rb] = 1'b1;
          y_in        = 1'b1;
          state_d     = T4;
        end else if (opcode == OP_HALT) begin
          state_d = HALT;
        end else begin
          // nop and every undefined opcode retire here; undefined ones flag illegal
          instr_done = 1'b1;
          illegal    = (opcode != OP_NOP);
          state_d    = run ? T0 : IDLE;
        end
      end
      T4: begin
        bus_sel[rc] = 1'b1;
        z_in        = 1'b1;
        alu_op      = opcode[3:0];
        state_d     = T5;
      end
      T5: begin
        bus_sel[BUS_ZLOW] = 1'b1;
        // R0 is read-only, so a write-back to it is suppressed
        reg_in[ra]        = (ra != 4'd0);
        instr_done        = 1'b1;
        state_d           = run ? T0 : IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. Each instruction is expanded by
// a reference model into the list of per-cycle output vectors the
// micro-sequence should produce. The DUT is then compared against that list
// cycle by cycle.

module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, run, mem_ready;
  logic [31:0] ir;
  logic [23:0] bus_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, read, inc_pc;
  logic [3:0]  alu_op;
  logic        instr_done, illegal, halted;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Strobe byte order: {pc_in, ir_in, mar_in, mdr_in, y_in, z_in, read, inc_pc}
  localparam logic [7:0] ST_PC  = 8'h80;
  localparam logic [7:0] ST_IR  = 8'h40;
  localparam logic [7:0] ST_MAR = 8'h20;
  localparam logic [7:0] ST_MDR = 8'h10;
  localparam logic [7:0] ST_Y   = 8'h08;
  localparam logic [7:0] ST_Z   = 8'h04;
  localparam logic [7:0] ST_RD  = 8'h02;
  localparam logic [7:0] ST_INC = 8'h01;

  localparam logic [31:0] IR_ADD  = 32'h01890000;
  localparam logic [31:0] IR_RA0  = 32'h00090000;
  localparam logic [31:0] IR_ILL  = 32'hE0000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  logic [54:0] obs;
  logic [54:0] exp_q[$];

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk        (clk),
    .clr        (clr),
    .run        (run),
    .mem_ready  (mem_ready),
    .ir         (ir),
    .bus_sel    (bus_sel),
    .reg_in     (reg_in),
    .pc_in      (pc_in),
    .ir_in      (ir_in),
    .mar_in     (mar_in),
    .mdr_in     (mdr_in),
    .y_in       (y_in),
    .z_in       (z_in),
    .read       (read),
    .inc_pc     (inc_pc),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .illegal    (illegal),
    .halted     (halted)
  );

  assign obs = {bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
                read, inc_pc, alu_op, instr_done, illegal, halted};

  task automatic check(input string tag, input logic [54:0] got, input logic [54:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [54:0] mk(input logic [23:0] b, input logic [15:0] r,
                                     input logic [7:0] s, input logic [3:0] a,
                                     input logic d, input logic il, input logic h);
    return {b, r, s, a, d, il, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the per-cycle outputs for one instruction, taken from
  // the fetch/execute rules. waits is the number of extra T1 cycles.
  task automatic build(input logic [31:0] v, input int unsigned waits);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = v[31:27]; ra = v[26:23]; rb = v[22:19]; rc = v[18:15];
    exp_q.delete();
    exp_q.push_back(mk(24'd1 << 20, '0, ST_MAR | ST_INC | ST_Z, '0, 1'b0, 1'b0, 1'b0));
    for (int unsigned k = 0; k <= waits; k++)
      exp_q.push_back(mk(24'd1 << 19, '0, ST_PC | ST_RD | ST_MDR, '0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(24'd1 << 21, '0, ST_IR, '0, 1'b0, 1'b0, 1'b0));
    if (op < 5'd12) begin
      exp_q.push_back(mk(24'd1 << rb, '0, ST_Y, '0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(24'd1 << rc, '0, ST_Z, op[3:0], 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(24'd1 << 19, (ra == 4'd0) ? 16'd0 : (16'd1 << ra), '0, '0,
                         1'b1, 1'b0, 1'b0));
    end else if (op == 5'd26) begin
      exp_q.push_back(mk('0, '0, '0, '0, 1'b1, 1'b0, 1'b0));
    end else if (op == 5'd27) begin
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(mk('0, '0, '0, '0, 1'b1, 1'b1, 1'b0));
    end
  endtask

  // Entered with the DUT already in T0. abort_at >= 0 raises clr at that step.
  task automatic run_instr(input logic [31:0] v, input int unsigned waits,
                           input int abort_at, input logic run_next, input string tag);
    build(v, waits);
    ir = v;
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), obs, exp_q[i]);
`ifdef SEQ_MEM_WAIT_EN
      mem_ready = !(i >= 1 && i <= int'(waits));
`else
      mem_ready = 1'($urandom_range(0, 1));
`endif
      if (i == exp_q.size() - 1) run = run_next;
      if (i == abort_at) begin
        clr = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] v;
    int unsigned w;
    logic        rn;

    // clr wins over run=1
    clr = 1'b1; run = 1'b1; mem_ready = 1'b0; ir = '0;
    tick(); tick();
    check("reset_idle", obs, '0);
    clr = 1'b0; run = 1'b0;
    tick();
    check("idle_hold", obs, '0);
    run = 1'b1;
    tick();

    run_instr(IR_ADD, 0, -1, 1'b1, "add");
    run_instr(IR_RA0, 0, -1, 1'b1, "ra0");
    run_instr(IR_ILL, 0, -1, 1'b1, "illegal");
    run_instr(IR_NOP, 0, -1, 1'b1, "nop");
`ifdef SEQ_MEM_WAIT_EN
    run_instr(IR_ADD, 3, -1, 1'b1, "wait3");
`else
    run_instr(IR_ADD, 0, -1, 1'b1, "nowait");
`endif

    // clr in T4 aborts the instruction, then fetch restarts
    run_instr(IR_ADD, 0, 4, 1'b1, "abort");
    check("abort_idle", obs, '0);
    clr = 1'b0; run = 1'b1;
    tick();
    run_instr(IR_ADD, 0, -1, 1'b0, "restart");
    check("stop_idle", obs, '0);
    tick();
    check("stop_idle2", obs, '0);
    run = 1'b1;
    tick();

    for (int n = 0; n < 40; n++) begin
      w = $urandom_range(0, 9);
      if (w < 6) op = 5'($urandom_range(0, 11));
      else if (w < 8) op = 5'd26;
      else begin
        op = 5'($urandom_range(12, 29));
        if (op >= 5'd26) op = op + 5'd2;
      end
      v = {op, 27'($urandom)};
`ifdef SEQ_MEM_WAIT_EN
      w = $urandom_range(0, 3);
`else
      w = 0;
`endif
      rn = ($urandom_range(0, 4) != 0);
      run_instr(v, w, -1, rn, $sformatf("rnd%0d", n));
      if (!rn) begin
        check($sformatf("rnd%0d_idle", n), obs, '0);
        run = 1'b1;
        tick();
      end
    end

    // halt holds despite run=1 until clr
    run_instr(IR_HALT, 0, -1, 1'b1, "halt");
    for (int k = 0; k < 20; k++) begin
      check($sformatf("halted%0d", k), obs, mk('0, '0, '0, '0, 1'b0, 1'b0, 1'b1));
      tick();
    end
    clr = 1'b1;
    tick();
    check("halt_clr", obs, '0);
    clr = 1'b0; run = 1'b0;
    tick();
    check("halt_clr_idle", obs, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
